// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// The optional performance counters are enabled with the PIPE_STAGE_PERF_EN macro.
package pipe_pkg;

  // Occupancy states of the two-entry stage: nothing held, main only, main plus skid
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  // Width of the stall and bubble performance counters
  localparam int PERF_CNT_W = 32;

  // Number of entries held in a given state
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      PS_EMPTY: occ = 2'd0;
      PS_BUSY:  occ = 2'd1;
      PS_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage performance statistics.
// Cleared only by reset; sticks at all-ones once it gets there.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  // Count one per cycle with inc high, stopping at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// The main register drives the outputs; the skid register catches the one
// entry that can arrive while in_ready is still high after downstream stalls.
// in_ready is a flop so the upstream ready path is not combinational.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

  pipe_state_e       state;
  pipe_state_e       state_n;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_n;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic              ready_q;
  logic              ready_n;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != PS_EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign in_ready  = ready_q;
  assign occupancy = state_occupancy(state);

  assign in_fire  = in_valid & ready_q;
  assign out_fire = out_valid & out_ready;

  // State, storage and ready flops; reset acts immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PS_EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      main_ctrl <= main_ctrl_n;
      skid_data <= skid_data_n;
      skid_ctrl <= skid_ctrl_n;
      ready_q   <= ready_n;
    end
  end

  // Next-state and datapath selection; flush overrides every handshake
  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    main_ctrl_n = main_ctrl;
    skid_data_n = skid_data;
    skid_ctrl_n = skid_ctrl;

    if (flush) begin
      state_n     = PS_EMPTY;
      main_ctrl_n = CTRL_BUBBLE;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state_n     = PS_BUSY;
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
          end else begin
            main_ctrl_n = CTRL_BUBBLE;
          end
        end

        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
          end else if (in_fire) begin
            state_n     = PS_FULL;
            skid_data_n = in_data;
            skid_ctrl_n = in_ctrl;
          end else if (out_fire) begin
            state_n     = PS_EMPTY;
            main_ctrl_n = CTRL_BUBBLE;
          end
        end

        PS_FULL: begin
          if (out_fire) begin
            state_n     = PS_BUSY;
            main_data_n = skid_data;
            main_ctrl_n = skid_ctrl;
          end
        end

        default: begin
          state_n     = PS_EMPTY;
          main_ctrl_n = CTRL_BUBBLE;
        end
      endcase
    end

    ready_n = (state_n != PS_FULL);
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(
    .WIDTH(PERF_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

  pipe_sat_counter #(
    .WIDTH(PERF_CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~out_valid & out_ready),
    .count(bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios followed by random traffic,
// compared against a queue-based model of the stage.
// Define PIPE_STAGE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] BUBBLE = 8'h00;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  entry_t      model_q[$];
  logic        model_ready;
  logic [31:0] model_stall;
  logic [31:0] model_bubble;
  int          checks;
  int          errors;

  pipe_stage_reg #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CTRL_BUBBLE(BUBBLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model's view of the stage
  task automatic check_output(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready));
    if (model_q.size() > 0) begin
      check({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(model_q[0].ctrl));
      check({tag, ".out_data"}, 64'(out_data), 64'(model_q[0].data));
    end else begin
      check({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(BUBBLE));
    end
`ifdef PIPE_STAGE_PERF_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(model_stall));
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(model_bubble));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic apply_stimulus(input logic v, input logic [CTRL_W-1:0] c,
                                input logic [DATA_W-1:0] d, input logic ordy,
                                input logic fl, input string tag);
    logic   in_fire_m;
    logic   out_fire_m;
    entry_t e;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    in_fire_m  = v && model_ready;
    out_fire_m = (model_q.size() > 0) && ordy;
    if (model_q.size() > 0 && !ordy && model_stall != 32'hFFFF_FFFF) model_stall++;
    if (model_q.size() == 0 && ordy && model_bubble != 32'hFFFF_FFFF) model_bubble++;
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (out_fire_m) void'(model_q.pop_front());
      if (in_fire_m) begin
        e.ctrl = c;
        e.data = d;
        model_q.push_back(e);
      end
    end
    model_ready = (model_q.size() != 2);
    check_output(tag);
  endtask

  // Assert reset between edges and check that outputs clear without a clock
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_q.delete();
    model_ready  = 1'b1;
    model_stall  = '0;
    model_bubble = '0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(BUBBLE));
    check({tag, ".out_data"}, 64'(out_data), 64'd0);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".occupancy"}, 64'(occupancy), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed scenarios, then randomized traffic
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_ctrl      = '0;
    in_data      = '0;
    out_ready    = 1'b0;
    model_ready  = 1'b1;
    model_stall  = '0;
    model_bubble = '0;

    $display("[TB] reset");
    do_reset("reset0");

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, CTRL_W'(8'h81 + i), DATA_W'(32'h11 + i), 1'b1, 1'b0, "stream");
      check("stream.expected_data", 64'(out_data), 64'(32'h11 + i));
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "stream_drain");

    $display("[TB] backpressure");
    apply_stimulus(1'b1, 8'h0A, 32'hA, 1'b0, 1'b0, "bp_pushA");
    apply_stimulus(1'b1, 8'h0B, 32'hB, 1'b0, 1'b0, "bp_pushB");
    check("bp.full_occ", 64'(occupancy), 64'd2);
    check("bp.full_ready", 64'(in_ready), 64'd0);
    apply_stimulus(1'b1, 8'h0D, 32'hD, 1'b0, 1'b0, "bp_refused");
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "bp_popA");
    check("bp.second_is_B", 64'(out_data), 64'hB);
    check("bp.ready_back", 64'(in_ready), 64'd1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "bp_popB");

    $display("[TB] flush while full");
    apply_stimulus(1'b1, 8'h21, 32'h21, 1'b0, 1'b0, "fl_push1");
    apply_stimulus(1'b1, 8'h22, 32'h22, 1'b0, 1'b0, "fl_push2");
    apply_stimulus(1'b1, 8'h0C, 32'hC, 1'b0, 1'b1, "fl_flush");
    check("flush.occ", 64'(occupancy), 64'd0);
    check("flush.ctrl", 64'(out_ctrl), 64'(BUBBLE));
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "fl_after");
    check("flush.no_C", 64'(out_valid), 64'd0);

    $display("[TB] async reset while full");
    apply_stimulus(1'b1, 8'h31, 32'h31, 1'b0, 1'b0, "ar_push1");
    apply_stimulus(1'b1, 8'h32, 32'h32, 1'b0, 1'b0, "ar_push2");
    do_reset("reset_mid");
    apply_stimulus(1'b1, 8'h05, 32'h5, 1'b1, 1'b0, "ar_push5");
    check("ar.data5", 64'(out_data), 64'h5);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "ar_drain");

`ifdef PIPE_STAGE_PERF_EN
    $display("[TB] performance counters");
    do_reset("reset_perf");
    apply_stimulus(1'b1, 8'h41, 32'h41, 1'b0, 1'b0, "perf_push");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, "perf_stall");
    check("perf.stall5", 64'(stall_cnt), 64'd5);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "perf_pop");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "perf_bubble");
    check("perf.bubble3", 64'(bubble_cnt), 64'd3);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "perf_flush");
    check("perf.stall_kept", 64'(stall_cnt), 64'd5);
    check("perf.bubble_kept", 64'(bubble_cnt), 64'd3);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), CTRL_W'($urandom_range(0, 255)), $urandom,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
